// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard controller: sequencer states,
// protocol byte values and the decoded event layout.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GOT_E0,
    GOT_F0,
    GOT_E0F0,
    EMIT
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT        = 8'hE0;
  localparam logic [7:0] PS2_BRK        = 8'hF0;
  localparam logic [7:0] PS2_FAKE_SHIFT = 8'h12;
  localparam logic [7:0] PS2_BAT        = 8'hAA;
  localparam logic [7:0] PS2_ACK        = 8'hFA;
  localparam logic [7:0] PS2_ECHO       = 8'hEE;
  localparam logic [7:0] PS2_RESEND     = 8'hFE;
  localparam logic [7:0] PS2_ERR0       = 8'h00;
  localparam logic [7:0] PS2_ERR1       = 8'hFF;
  localparam logic [7:0] PS2_PAUSE      = 8'hE1;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       rep;
  } ps2_evt_t;

  // Bytes that carry no key information when seen outside a prefix.
  function automatic logic ps2_is_discard(input logic [7:0] b);
    return (b == PS2_ERR0) || (b == PS2_BAT) || (b == PS2_ECHO) ||
           (b == PS2_ACK)  || (b == PS2_RESEND) || (b == PS2_ERR1) ||
           (b == PS2_PAUSE);
  endfunction

endpackage

// File: rtl/bcd_counter2.sv
// Two-digit BCD incrementer; the value COUNT_MAX wraps to 00 on the next enable.
module bcd_counter2 #(
  parameter int unsigned COUNT_MAX = 99
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       en,
  output logic [7:0] count_bcd
);

  localparam logic [3:0] MAX_TENS = 4'(COUNT_MAX / 10);
  localparam logic [3:0] MAX_ONES = 4'(COUNT_MAX % 10);

  logic [3:0] ones_q, ones_d;
  logic [3:0] tens_q, tens_d;

  always_comb begin
    ones_d = ones_q;
    tens_d = tens_q;
    if (en) begin
      if ((tens_q == MAX_TENS) && (ones_q == MAX_ONES)) begin
        ones_d = '0;
        tens_d = '0;
      end else if (ones_q == 4'd9) begin
        ones_d = '0;
        tens_d = tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ones_q <= '0;
      tens_q <= '0;
    end else begin
      ones_q <= ones_d;
      tens_q <= tens_d;
    end
  end

  assign count_bcd = {tens_q, ones_q};

endmodule

// File: rtl/ps2_key_ctrl.sv
// PS/2 scancode sequencer: strips E0/F0 prefixes, emits one event per key
// sequence over valid/ready, and tracks the held key and BCD press count.
module ps2_key_ctrl
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 5000000,
  parameter int unsigned COUNT_MAX      = 99
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_break,
  output logic       evt_repeat,
  output logic       key_held,
  output logic [7:0] held_code,
  output logic       held_ext,
  output logic [7:0] count_bcd,
  output logic       proto_err
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  ps2_state_e    state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  ps2_evt_t      evt_q, evt_d;
  logic          held_q, held_d;
  logic [7:0]    held_code_q, held_code_d;
  logic          held_ext_q, held_ext_d;
  logic          err_q, err_d;
  logic          cnt_en;
  logic          take;
  logic          emit, emit_ext, emit_brk, match;

  assign rx_ready = (state_q != EMIT);
  assign take     = rx_valid && rx_ready;

  always_comb begin
    state_d     = state_q;
    tmo_d       = '0;
    evt_d       = evt_q;
    held_d      = held_q;
    held_code_d = held_code_q;
    held_ext_d  = held_ext_q;
    err_d       = 1'b0;
    cnt_en      = 1'b0;
    emit        = 1'b0;
    emit_ext    = 1'b0;
    emit_brk    = 1'b0;
    match       = 1'b0;

    case (state_q)
      IDLE: begin
        if (take) begin
          if (rx_data == PS2_EXT)          state_d = GOT_E0;
          else if (rx_data == PS2_BRK)     state_d = GOT_F0;
          else if (!ps2_is_discard(rx_data)) emit  = 1'b1;
        end
      end
      GOT_E0: begin
        if (take) begin
          if (rx_data == PS2_BRK)             state_d = GOT_E0F0;
          else if (rx_data == PS2_EXT)        err_d   = 1'b1;
          else if (rx_data == PS2_FAKE_SHIFT) state_d = IDLE;
          else begin
            emit     = 1'b1;
            emit_ext = 1'b1;
          end
        end
      end
      GOT_F0: begin
        if (take) begin
          if ((rx_data == PS2_EXT) || (rx_data == PS2_BRK)) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            emit     = 1'b1;
            emit_brk = 1'b1;
          end
        end
      end
      GOT_E0F0: begin
        if (take) begin
          if ((rx_data == PS2_EXT) || (rx_data == PS2_BRK)) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else if (rx_data == PS2_FAKE_SHIFT) begin
            state_d = IDLE;
          end else begin
            emit     = 1'b1;
            emit_ext = 1'b1;
            emit_brk = 1'b1;
          end
        end
      end
      EMIT: begin
        if (evt_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Prefix states wait for a follow-on byte; the timer only advances while idle there.
    if ((state_q == GOT_E0 || state_q == GOT_F0 || state_q == GOT_E0F0) && !take) begin
      if (tmo_q == TMO_LAST) begin
        err_d   = 1'b1;
        state_d = IDLE;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end

    if (emit) begin
      state_d    = EMIT;
      match      = held_q && (rx_data == held_code_q) && (emit_ext == held_ext_q);
      evt_d.code = rx_data;
      evt_d.ext  = emit_ext;
      evt_d.brk  = emit_brk;
      evt_d.rep  = 1'b0;
      if (!emit_brk) begin
        evt_d.rep = match;
        if (!match) begin
          held_d      = 1'b1;
          held_code_d = rx_data;
          held_ext_d  = emit_ext;
          cnt_en      = 1'b1;
        end
      end else if (match) begin
        held_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      tmo_q       <= '0;
      evt_q       <= '0;
      held_q      <= 1'b0;
      held_code_q <= '0;
      held_ext_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      evt_q       <= evt_d;
      held_q      <= held_d;
      held_code_q <= held_code_d;
      held_ext_q  <= held_ext_d;
      err_q       <= err_d;
    end
  end

  bcd_counter2 #(
    .COUNT_MAX(COUNT_MAX)
  ) u_count (
    .clk      (clk),
    .resetn   (resetn),
    .en       (cnt_en),
    .count_bcd(count_bcd)
  );

  assign evt_valid  = (state_q == EMIT);
  assign evt_code   = evt_q.code;
  assign evt_ext    = evt_q.ext;
  assign evt_break  = evt_q.brk;
  assign evt_repeat = evt_q.rep;
  assign key_held   = held_q;
  assign held_code  = held_code_q;
  assign held_ext   = held_ext_q;
  assign proto_err  = err_q;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Bench for ps2_key_ctrl: fixed vector table, directed corner sequences and
// random byte streams, all checked against a sequence-level reference model.
module tb_ps2_key_ctrl;

  localparam int unsigned TMO  = 16;
  localparam int unsigned CMAX = 99;

  logic       clk = 1'b0;
  logic       resetn;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;
  logic       evt_repeat;
  logic       key_held;
  logic [7:0] held_code;
  logic       held_ext;
  logic [7:0] count_bcd;
  logic       proto_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ps2_key_ctrl #(
    .TIMEOUT_CYCLES(TMO),
    .COUNT_MAX     (CMAX)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_code  (evt_code),
    .evt_ext   (evt_ext),
    .evt_break (evt_break),
    .evt_repeat(evt_repeat),
    .key_held  (key_held),
    .held_code (held_code),
    .held_ext  (held_ext),
    .count_bcd (count_bcd),
    .proto_err (proto_err)
  );

  // Reference model: pending prefix bytes as a queue, presses as an integer.
  logic [7:0] pend[$];
  logic       ev_pend;
  logic [7:0] m_code;
  logic       m_ext, m_brk, m_rep;
  logic       m_held;
  logic [7:0] m_hcode;
  logic       m_hext;
  int         m_n;
  logic       m_err;
  int         m_tmo;

  function automatic logic is_junk(input logic [7:0] b);
    return b == 8'h00 || b == 8'hAA || b == 8'hEE || b == 8'hFA ||
           b == 8'hFE || b == 8'hFF || b == 8'hE1;
  endfunction

  function automatic logic [7:0] to_bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  task automatic model_emit(input logic [7:0] code, input logic ext, input logic brk);
    logic same;
    same    = m_held && (code == m_hcode) && (ext == m_hext);
    ev_pend = 1'b1;
    m_code  = code;
    m_ext   = ext;
    m_brk   = brk;
    m_rep   = 1'b0;
    if (!brk) begin
      m_rep = same;
      if (!same) begin
        m_held  = 1'b1;
        m_hcode = code;
        m_hext  = ext;
        m_n     = (m_n == int'(CMAX)) ? 0 : m_n + 1;
      end
    end else if (same) begin
      m_held = 1'b0;
    end
  endtask

  task automatic model_edge(input logic rstn, input logic rv, input logic [7:0] rd, input logic er);
    logic [7:0] seq[$];
    if (!rstn) begin
      pend.delete();
      ev_pend = 0; m_code = '0; m_ext = 0; m_brk = 0; m_rep = 0;
      m_held = 0; m_hcode = '0; m_hext = 0; m_n = 0; m_err = 0; m_tmo = 0;
      return;
    end
    m_err = 1'b0;
    if (ev_pend) begin
      if (er) ev_pend = 1'b0;
    end else if (rv) begin
      m_tmo = 0;
      seq = pend;
      seq.push_back(rd);
      pend.delete();
      if (rd == 8'hE0 || rd == 8'hF0) begin
        if (seq.size() == 1 || (seq.size() == 2 && seq[0] == 8'hE0 && rd == 8'hF0)) begin
          pend = seq;
        end else if (seq.size() == 2 && seq[0] == 8'hE0 && rd == 8'hE0) begin
          m_err = 1'b1;
          pend.push_back(8'hE0);
        end else begin
          m_err = 1'b1;
        end
      end else if (seq.size() == 1 && is_junk(rd)) begin
        m_err = 1'b0;
      end else if (seq[0] == 8'hE0 && rd == 8'h12) begin
        m_err = 1'b0;
      end else begin
        model_emit(rd, seq[0] == 8'hE0, seq.size() >= 2 && seq[seq.size()-2] == 8'hF0);
      end
    end else if (pend.size() != 0) begin
      m_tmo++;
      if (m_tmo >= int'(TMO)) begin
        m_err = 1'b1;
        pend.delete();
        m_tmo = 0;
      end
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk1("rx_ready",   rx_ready,   !ev_pend);
    chk1("evt_valid",  evt_valid,  ev_pend);
    chk8("evt_code",   evt_code,   m_code);
    chk1("evt_ext",    evt_ext,    m_ext);
    chk1("evt_break",  evt_break,  m_brk);
    chk1("evt_repeat", evt_repeat, m_rep);
    chk1("key_held",   key_held,   m_held);
    chk8("held_code",  held_code,  m_hcode);
    chk1("held_ext",   held_ext,   m_hext);
    chk8("count_bcd",  count_bcd,  to_bcd(m_n));
    chk1("proto_err",  proto_err,  m_err);
  endtask

  // Called at a falling edge: drive, clock once, update model, sample at next falling edge.
  task automatic cyc(input logic rv, input logic [7:0] rd, input logic er);
    rx_valid  = rv;
    rx_data   = rd;
    evt_ready = er;
    @(posedge clk);
    model_edge(resetn, rv, rd, er);
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    cyc(1'b0, 8'h00, 1'b0);
    resetn = 1'b1;
  endtask

  task automatic press(input logic [7:0] b);
    cyc(1'b1, b, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
  endtask

  typedef struct {
    logic       rv;
    logic [7:0] rd;
    logic       er;
    logic       ev;
    logic [7:0] code;
    logic       ext, brk, rep, held;
    logic [7:0] hcode;
    logic [7:0] cnt;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mkv(logic rv, logic [7:0] rd, logic er, logic ev, logic [7:0] code,
                               logic ext, logic brk, logic rep, logic held,
                               logic [7:0] hcode, logic [7:0] cnt);
    vec_t v;
    v.rv = rv; v.rd = rd; v.er = er; v.ev = ev; v.code = code; v.ext = ext;
    v.brk = brk; v.rep = rep; v.held = held; v.hcode = hcode; v.cnt = cnt;
    return v;
  endfunction

  logic [7:0] picks[10];
  int pulses, first_idx;

  initial begin
    resetn = 1'b0; rx_valid = 1'b0; rx_data = '0; evt_ready = 1'b0;
    pend.delete();
    ev_pend = 0; m_code = '0; m_ext = 0; m_brk = 0; m_rep = 0;
    m_held = 0; m_hcode = '0; m_hext = 0; m_n = 0; m_err = 0; m_tmo = 0;
    @(negedge clk);
    do_reset();
    chk1("reset_evt_valid", evt_valid, 1'b0);
    chk8("reset_count", count_bcd, 8'h00);

    //          rv rd     er  ev code   ext brk rep held hcode  cnt
    vq.push_back(mkv(1, 8'h1C, 1, 1, 8'h1C, 0, 0, 0, 1, 8'h1C, 8'h01));
    vq.push_back(mkv(1, 8'hF0, 1, 0, 8'h1C, 0, 0, 0, 1, 8'h1C, 8'h01));
    vq.push_back(mkv(1, 8'hF0, 1, 0, 8'h1C, 0, 0, 0, 1, 8'h1C, 8'h01));
    vq.push_back(mkv(1, 8'h1C, 1, 1, 8'h1C, 0, 1, 0, 0, 8'h1C, 8'h01));
    vq.push_back(mkv(0, 8'h00, 1, 0, 8'h1C, 0, 1, 0, 0, 8'h1C, 8'h01));
    vq.push_back(mkv(1, 8'hE0, 1, 0, 8'h1C, 0, 1, 0, 0, 8'h1C, 8'h01));
    vq.push_back(mkv(1, 8'h75, 1, 1, 8'h75, 1, 0, 0, 1, 8'h75, 8'h02));
    vq.push_back(mkv(0, 8'h00, 1, 0, 8'h75, 1, 0, 0, 1, 8'h75, 8'h02));
    vq.push_back(mkv(1, 8'hE0, 1, 0, 8'h75, 1, 0, 0, 1, 8'h75, 8'h02));
    vq.push_back(mkv(1, 8'hF0, 1, 0, 8'h75, 1, 0, 0, 1, 8'h75, 8'h02));
    vq.push_back(mkv(1, 8'h75, 1, 1, 8'h75, 1, 1, 0, 0, 8'h75, 8'h02));
    vq.push_back(mkv(0, 8'h00, 1, 0, 8'h75, 1, 1, 0, 0, 8'h75, 8'h02));
    vq.push_back(mkv(1, 8'hE0, 1, 0, 8'h75, 1, 1, 0, 0, 8'h75, 8'h02));
    vq.push_back(mkv(1, 8'h12, 1, 0, 8'h75, 1, 1, 0, 0, 8'h75, 8'h02));
    vq.push_back(mkv(0, 8'h00, 1, 0, 8'h75, 1, 1, 0, 0, 8'h75, 8'h02));
    vq.push_back(mkv(1, 8'hAA, 1, 0, 8'h75, 1, 1, 0, 0, 8'h75, 8'h02));
    vq.push_back(mkv(0, 8'h00, 1, 0, 8'h75, 1, 1, 0, 0, 8'h75, 8'h02));

    for (int i = 0; i < vq.size(); i++) begin
      cyc(vq[i].rv, vq[i].rd, vq[i].er);
      chk1($sformatf("tbl%0d_valid", i), evt_valid,  vq[i].ev);
      chk8($sformatf("tbl%0d_code", i),  evt_code,   vq[i].code);
      chk1($sformatf("tbl%0d_ext", i),   evt_ext,    vq[i].ext);
      chk1($sformatf("tbl%0d_brk", i),   evt_break,  vq[i].brk);
      chk1($sformatf("tbl%0d_rep", i),   evt_repeat, vq[i].rep);
      chk1($sformatf("tbl%0d_held", i),  key_held,   vq[i].held);
      chk8($sformatf("tbl%0d_hcode", i), held_code,  vq[i].hcode);
      chk8($sformatf("tbl%0d_cnt", i),   count_bcd,  vq[i].cnt);
    end

    // Typematic repeats.
    do_reset();
    cyc(1'b1, 8'h1C, 1'b1); chk1("typ1_rep", evt_repeat, 1'b0); cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b1, 8'h1C, 1'b1); chk1("typ2_rep", evt_repeat, 1'b1); cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b1, 8'h1C, 1'b1); chk1("typ3_rep", evt_repeat, 1'b1); cyc(1'b0, 8'h00, 1'b1);
    chk8("typ_count", count_bcd, 8'h01);
    cyc(1'b1, 8'hF0, 1'b1);
    cyc(1'b1, 8'h1C, 1'b1);
    chk1("typ_brk", evt_break, 1'b1);
    chk1("typ_brk_rep", evt_repeat, 1'b0);
    chk1("typ_released", key_held, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    press(8'h32);
    chk8("typ_count2", count_bcd, 8'h02);

    // Backpressure: event must hold while the next byte waits.
    do_reset();
    cyc(1'b1, 8'h1C, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 8'h2A, 1'b0);
      chk1("bp_rx_ready", rx_ready, 1'b0);
      chk1("bp_valid", evt_valid, 1'b1);
      chk8("bp_code", evt_code, 8'h1C);
    end
    cyc(1'b1, 8'h2A, 1'b1);
    chk1("bp_drain", evt_valid, 1'b0);
    cyc(1'b1, 8'h2A, 1'b1);
    chk1("bp_next_valid", evt_valid, 1'b1);
    chk8("bp_next_code", evt_code, 8'h2A);
    cyc(1'b0, 8'h00, 1'b1);

    // Prefix timeout.
    do_reset();
    cyc(1'b1, 8'hF0, 1'b1);
    pulses = 0;
    first_idx = -1;
    for (int i = 0; i < 40; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      if (proto_err) begin
        pulses++;
        if (first_idx < 0) first_idx = i;
      end
    end
    chk8("tmo_pulses", 8'(pulses), 8'd1);
    chk8("tmo_when", 8'(first_idx), 8'(TMO - 1));
    cyc(1'b1, 8'h1C, 1'b1);
    chk1("tmo_after_valid", evt_valid, 1'b1);
    chk1("tmo_after_brk", evt_break, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);

    // Counter wrap at COUNT_MAX.
    do_reset();
    for (int i = 0; i < 98; i++) press((i % 2) ? 8'h32 : 8'h1C);
    chk8("wrap_98", count_bcd, 8'h98);
    press(8'h1C);
    chk8("wrap_99", count_bcd, 8'h99);
    press(8'h32);
    chk8("wrap_00", count_bcd, 8'h00);

    // Reset in the middle of an E0 sequence.
    press(8'h1C);
    cyc(1'b1, 8'hE0, 1'b1);
    resetn = 1'b0;
    cyc(1'b1, 8'h75, 1'b1);
    chk1("mrst_valid", evt_valid, 1'b0);
    chk1("mrst_held", key_held, 1'b0);
    chk8("mrst_hcode", held_code, 8'h00);
    chk8("mrst_count", count_bcd, 8'h00);
    chk8("mrst_code", evt_code, 8'h00);
    resetn = 1'b1;
    cyc(1'b0, 8'h00, 1'b1);
    chk1("mrst_noevt", evt_valid, 1'b0);
    cyc(1'b1, 8'h75, 1'b1);
    chk1("mrst_plain_ext", evt_ext, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);

    // Random byte streams.
    picks[0] = 8'hE0; picks[1] = 8'hF0; picks[2] = 8'h12; picks[3] = 8'h1C;
    picks[4] = 8'h32; picks[5] = 8'h75; picks[6] = 8'hAA; picks[7] = 8'h00;
    picks[8] = 8'hE1; picks[9] = 8'hFA;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        for (int j = 0; j < 20; j++) cyc(1'b0, 8'h00, 1'b1);
      end
      resetn = ($urandom_range(0, 499) != 0);
      cyc($urandom_range(0, 99) < 60, picks[$urandom_range(0, 9)], $urandom_range(0, 99) < 70);
      resetn = 1'b1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ps2_key_ctrl.md
Name: ps2_key_ctrl

Overview:
Sequencer between the PS/2 byte receiver and the display/count blocks of the keyboard design. It consumes raw received bytes and tracks prefix state (E0 extended, F0 break). It emits one decoded key event per complete make/break sequence through a valid/ready handshake. It also owns the held-key indicator and the BCD press counter that feed the segment decoders.

Parameters:
TIMEOUT_CYCLES, 5000000, clk cycles allowed between a prefix byte and its follow-on byte before the partial sequence is dropped
COUNT_MAX, 99, last press-count value before wrap to 0 (must be 1..99)

Ports:
clk  in  1  system clock, all logic rising-edge
resetn  in  1  synchronous active-low reset
rx_valid  in  1  receiver has a byte available
rx_data  in  8  received byte
rx_ready  out  1  controller accepts rx_data this cycle
evt_valid  out  1  decoded key event available
evt_ready  in  1  consumer accepts event this cycle
evt_code  out  8  scancode of event (prefixes stripped)
evt_ext  out  1  event carried E0 prefix
evt_break  out  1  event is a release (F0)
evt_repeat  out  1  make of the already-held key (typematic)
key_held  out  1  a key is currently held
held_code  out  8  code of held key (valid when key_held)
held_ext  out  1  ext flag of held key
count_bcd  out  8  distinct presses, BCD {tens,ones}
proto_err  out  1  one-cycle pulse on timeout or sequence error

Behaviour:
- Reset (resetn=0 at a clk edge): state IDLE; evt_valid=0; evt_code/flags=0; key_held=0; held_code=0; held_ext=0; count_bcd=8'h00; proto_err=0; timeout counter=0. This applies mid-sequence, and any partial prefix is discarded.
- A byte is consumed on a cycle with rx_valid && rx_ready.
- rx_ready=1 in IDLE, GOT_E0, GOT_F0, GOT_E0F0. It is 0 in EMIT.
- States:
  - IDLE: E0 -> GOT_E0; F0 -> GOT_F0; 00/AA/EE/FA/FE/FF/E1 -> discarded, stay IDLE; any other byte -> EMIT as make, ext=0.
  - GOT_E0: F0 -> GOT_E0F0; E0 -> proto_err, stay GOT_E0; 12 (fake shift) -> discarded, IDLE; other -> EMIT as make, ext=1.
  - GOT_F0: E0/F0 -> proto_err, IDLE; other -> EMIT as break, ext=0.
  - GOT_E0F0: E0/F0 -> proto_err, IDLE; 12 -> discarded, IDLE; other -> EMIT as break, ext=1.
  - EMIT: evt_valid=1 with fields stable; on evt_ready -> IDLE.
- evt_valid rises the cycle after the final byte is consumed (latency 1). Fields never change while evt_valid && !evt_ready.
- Held/count update on entry to EMIT, i.e. same edge evt_valid rises:
  - make where {code,ext} == held and key_held=1: evt_repeat=1, count unchanged.
  - make otherwise: evt_repeat=0; key_held=1; held_code/held_ext <= this key; count_bcd increments.
  - break matching held: key_held=0 (held_code retained).
  - break not matching: held unchanged.
  - break events always have evt_repeat=0.
- count_bcd: BCD increment with ones wrap 9->0 and carry into tens. A value equal to COUNT_MAX wraps to 8'h00; no other saturation.
- Timeout: counter runs only in GOT_E0/GOT_F0/GOT_E0F0 and clears on any consumed byte or state change. On reaching TIMEOUT_CYCLES-1: proto_err pulse, -> IDLE.
- The timeout counter and proto_err do not affect held state or count.

Decomposition:
- Package ps2_pkg: state enum (IDLE, GOT_E0, GOT_F0, GOT_E0F0, EMIT), byte constants PS2_EXT=E0, PS2_BRK=F0, PS2_FAKE_SHIFT=12, PS2_BAT=AA, PS2_ACK=FA, PS2_ECHO=EE, PS2_RESEND=FE, PS2_ERR0=00, PS2_ERR1=FF, PS2_PAUSE=E1, and the event field layout.
- One sub-module: bcd_counter2 (2-digit BCD incrementer with enable and COUNT_MAX wrap), reusable by the count display path.

Test Plan:
- Bytes 1C, F0, 1C with evt_ready=1: event {1C,ext0,brk0,rep0}, then {1C,ext0,brk1}. key_held 1 then 0. count_bcd=01.
- E0 75, then E0 F0 75: events {75,ext1,brk0}, {75,ext1,brk1}. Byte E0 12 alone yields no event. count_bcd=01.
- 1C, 1C, 1C (typematic), then F0 1C: three make events, the last two with rep=1, then a break. count_bcd=01. Then 32 gives count_bcd=02.
- evt_ready held 0 for 10 cycles after 1C while 2A is pending on rx: rx_ready=0, evt fields stable at 1C. After evt_ready=1, the next event is 2A.
- TIMEOUT_CYCLES=16: F0 then idle 16 cycles -> proto_err single pulse, state IDLE. Next byte 1C -> make event, not break.
- Preload to 98 via 98 distinct alternating presses, then two more presses: count_bcd 99 -> 00. Assert resetn=0 between E0 and 75: no event, all outputs at reset values next cycle.
